mem_arb2: RTL and testbench

MEM_ARB2 -- requirements
Module: mem_arb2

---
 rtl/mem_arb2_pkg.sv | 27 ++
 rtl/arb_rr2.sv | 17 +
 rtl/mem_arb2.sv | 135 +++++++++++++
 tb/tb_mem_arb2.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb2_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// State encoding and master ids are fixed so the bench and debug tools can decode them.
package mem_arb2_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAcc  = 2'b01,
    StResp = 2'b10
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Round-robin tie break: the master not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic id;
    if (req == 2'b11) begin
      id = ~last;
    end else if (req[1]) begin
      id = M1;
    end else begin
      id = M0;
    end
    return id;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin winner selection.
// Purely a function of the request vector and the last-served id.
module arb_rr2
  import mem_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = rr_pick(req, last);
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-master single-port memory arbiter with round-robin tie break.
// Requests are sampled only in idle; all outputs decode from registered state.
module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          arb_valid;
  logic          arb_id;

  arb_rr2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .valid (arb_valid),
    .id    (arb_id)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= M1;
      win_q   <= M0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          win_d   = arb_id;
          last_d  = arb_id;
          we_d    = (arb_id == M1) ? m1_we    : m0_we;
          adr_d   = (arb_id == M1) ? m1_adr   : m0_adr;
          wdata_d = (arb_id == M1) ? m1_wdata : m0_wdata;
          state_d = StAcc;
        end
      end
      StAcc:   state_d = we_q ? StIdle : StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted access never
  // emits a late strobe or pulse.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = adr_q;
    mem_wdata = wdata_q;
    busy      = rst && (state_q != StIdle);
    if (rst) begin
      case (state_q)
        StAcc: begin
          mem_en = 1'b1;
          mem_we = we_q;
          if (win_q == M1) begin
            m1_gnt = 1'b1;
          end else begin
            m0_gnt = 1'b1;
          end
        end
        StResp: begin
          if (win_q == M1) begin
            m1_rvalid = 1'b1;
            m1_rdata  = mem_rdata;
          end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with hand-computed expectations.
// A tiny memory model returns rd_value one cycle after each read strobe.
module tb_mem_arb2;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_adr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_adr, m1_wdata, m1_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [31:0] rd_value;

  int n_chk;
  int n_bad;

  mem_arb2 #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= rd_value;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gnt_cnt;
    int first;
    n_chk = 0;
    n_bad = 0;
    rst = 1'b0;
    {m0_req, m0_we, m1_req, m1_we} = '0;
    m0_adr = '0; m0_wdata = '0; m1_adr = '0; m1_wdata = '0;
    rd_value = '0;

    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_gnt", {m1_gnt, m0_gnt}, 0);
    check_eq("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check_eq("rst_mem_adr", mem_adr, 0);
    rst = 1'b1;

    // m0 read alone
    m0_req = 1; m0_we = 0; m0_adr = 32'h100; rd_value = 32'hDEADBEEF;
    step();
    check_eq("rd_m0_gnt", m0_gnt, 1);
    check_eq("rd_m1_gnt", m1_gnt, 0);
    check_eq("rd_mem_en", mem_en, 1);
    check_eq("rd_mem_we", mem_we, 0);
    check_eq("rd_mem_adr", mem_adr, 32'h100);
    check_eq("rd_busy", busy, 1);
    m0_req = 0;
    step();
    check_eq("rd_rvalid", m0_rvalid, 1);
    check_eq("rd_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("rd_m1_rvalid", m1_rvalid, 0);
    check_eq("rd_m1_rdata", m1_rdata, 0);
    check_eq("rd_resp_mem_en", mem_en, 0);
    step();
    check_eq("rd_idle_busy", busy, 0);
    check_eq("rd_idle_rvalid", m0_rvalid, 0);

    // m1 write alone
    m1_req = 1; m1_we = 1; m1_adr = 32'h20; m1_wdata = 32'h55;
    step();
    check_eq("wr_mem_en", mem_en, 1);
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_adr", mem_adr, 32'h20);
    check_eq("wr_mem_wdata", mem_wdata, 32'h55);
    check_eq("wr_m1_gnt", m1_gnt, 1);
    check_eq("wr_m0_gnt", m0_gnt, 0);
    m1_req = 0; m1_we = 0;
    step();
    check_eq("wr_idle_busy", busy, 0);
    check_eq("wr_no_rvalid", {m1_rvalid, m0_rvalid}, 0);

    // both held from reset release: writes alternate m0, m1, m0, m1
    rst = 0;
    m0_req = 1; m0_we = 1; m0_adr = 32'h40;
    m1_req = 1; m1_we = 1; m1_adr = 32'h44;
    step(); step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_m0_gnt", m0_gnt, (i % 2 == 0) ? 1 : 0);
      check_eq("rr_m1_gnt", m1_gnt, (i % 2 == 1) ? 1 : 0);
      check_eq("rr_mem_adr", mem_adr, (i % 2 == 0) ? 32'h40 : 32'h44);
      if (i == 3) begin
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
      end
      step();
    end

    // reset asserted in RESP aborts the read
    m0_req = 1; m0_adr = 32'h100; rd_value = 32'h12345678;
    step();
    check_eq("ab_m0_gnt", m0_gnt, 1);
    m0_req = 0;
    step();
    rst = 0;
    #1;
    check_eq("ab_rvalid", m0_rvalid, 0);
    check_eq("ab_busy_now", busy, 0);
    step();
    check_eq("ab_busy", busy, 0);
    check_eq("ab_mem_en", mem_en, 0);
    check_eq("ab_rvalid_next", m0_rvalid, 0);
    // last-served was m0 before reset; reset must hand the tie back to m0
    m0_req = 1; m0_we = 0; m0_adr = 32'h40;
    m1_req = 1; m1_we = 0; m1_adr = 32'h44;
    rst = 1;
    step();
    check_eq("ab_tie_m0", m0_gnt, 1);
    check_eq("ab_tie_m1", m1_gnt, 0);

    // address change during ACC is ignored
    m0_adr = 32'h80; m0_req = 0;
    rd_value = 32'hA5A5A5A5;
    #1;
    check_eq("hold_mem_adr", mem_adr, 32'h40);
    step();
    check_eq("hold_rvalid", m0_rvalid, 1);
    check_eq("hold_rdata", m0_rdata, 32'hA5A5A5A5);
    check_eq("hold_m1_rvalid", m1_rvalid, 0);
    check_eq("hold_m1_rdata", m1_rdata, 0);
    step();
    step();
    check_eq("pend_m1_gnt", m1_gnt, 1);
    check_eq("pend_m0_gnt", m0_gnt, 0);
    check_eq("pend_mem_adr", mem_adr, 32'h44);
    m1_req = 0;
    rd_value = 32'h0BADF00D;
    step();
    check_eq("pend_m1_rvalid", m1_rvalid, 1);
    check_eq("pend_m1_rdata", m1_rdata, 32'h0BADF00D);
    check_eq("pend_m0_rdata", m0_rdata, 0);
    step();

    // m1 write wins while m0 read waits; m0 granted exactly once afterwards
    m0_req = 1; m0_we = 1; m0_adr = 32'h8;
    step();
    check_eq("pre_m0_gnt", m0_gnt, 1);
    m0_req = 0;
    step();
    m1_req = 1; m1_we = 1; m1_adr = 32'hC; m1_wdata = 32'h77;
    m0_req = 1; m0_we = 0; m0_adr = 32'h10;
    step();
    check_eq("mix_m1_gnt", m1_gnt, 1);
    check_eq("mix_m0_gnt", m0_gnt, 0);
    check_eq("mix_mem_we", mem_we, 1);
    check_eq("mix_mem_wdata", mem_wdata, 32'h77);
    m1_req = 0; m1_we = 0;
    gnt_cnt = 0;
    first = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m0_gnt) begin
        gnt_cnt++;
        if (first < 0) first = i;
        m0_req = 0;
      end
    end
    check_eq("mix_m0_gnt_cnt", gnt_cnt, 1);
    check_eq("mix_m0_gnt_at", first, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
